// File: rtl/result_skid_stage_pkg.sv
// Shared definitions for the result skid stage: default widths, buffer state
// encoding, status bit positions and small entry/flag helpers.
package result_skid_stage_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b10
    } state_e;

    localparam int STAT_W   = 6;
    localparam int STAT_V   = 5;
    localparam int STAT_C   = 4;
    localparam int STAT_N   = 3;
    localparam int STAT_Z   = 2;
    localparam int STAT_LCO = 1;
    localparam int STAT_RCO = 0;

    // Register 0 is hard-wired, so a write aimed at it is dropped but still retired.
    function automatic logic make_wr(input logic reg_write, input logic addr_nonzero);
        return reg_write & addr_nonzero;
    endfunction

    function automatic logic [STAT_W-1:0] pack_flags(
        input logic v, input logic c, input logic n,
        input logic z, input logic lco, input logic rco
    );
        logic [STAT_W-1:0] flags_s;
        flags_s           = {STAT_W{1'b0}};
        flags_s[STAT_V]   = v;
        flags_s[STAT_C]   = c;
        flags_s[STAT_N]   = n;
        flags_s[STAT_Z]   = z;
        flags_s[STAT_LCO] = lco;
        flags_s[STAT_RCO] = rco;
        return flags_s;
    endfunction

endpackage

// File: rtl/result_skid_stage_entry_reg.sv
// One buffered result entry {data, addr, wr} with a load enable; clears on reset.
module result_entry_reg
    import result_skid_stage_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] d_data,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic              d_wr,
    output logic [DATA_W-1:0] q_data,
    output logic [ADDR_W-1:0] q_addr,
    output logic              q_wr
);

    // Entry storage, captured only when the owning stage asks for it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_data <= {DATA_W{1'b0}};
            q_addr <= {ADDR_W{1'b0}};
            q_wr   <= 1'b0;
        end else if (load) begin
            q_data <= d_data;
            q_addr <= d_addr;
            q_wr   <= d_wr;
        end
    end

endmodule

// File: rtl/result_skid_stage.sv
// Two-entry in-order skid buffer between a function unit and the register-file
// write port; also owns the architectural status flags.
module result_skid_stage
    import result_skid_stage_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] F,
    input  logic              V,
    input  logic              C,
    input  logic              N,
    input  logic              Z,
    input  logic              LCO,
    input  logic              RCO,
    input  logic [ADDR_W-1:0] dest_addr,
    input  logic              reg_write,
    input  logic              flag_load,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_wr,
    output logic [5:0]        status
);

    state_e            state_r;
    state_e            state_s;
    logic              in_ready_r;
    logic              out_valid_r;
    logic [5:0]        status_r;
    logic              push_s;
    logic              pop_s;
    logic              in_wr_s;
    logic              head_load_s;
    logic              tail_load_s;
    logic              head_from_tail_s;
    logic [DATA_W-1:0] head_d_data_s;
    logic [ADDR_W-1:0] head_d_addr_s;
    logic              head_d_wr_s;
    logic [DATA_W-1:0] tail_data_r;
    logic [ADDR_W-1:0] tail_addr_r;
    logic              tail_wr_r;

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign status    = status_r;

    assign push_s  = in_valid & in_ready_r;
    assign pop_s   = out_valid_r & out_ready;
    assign in_wr_s = make_wr(reg_write, dest_addr != {ADDR_W{1'b0}});

    // Next state and slot-load decisions; the head slot always holds the oldest entry.
    always_comb begin
        state_s          = state_r;
        head_load_s      = 1'b0;
        tail_load_s      = 1'b0;
        head_from_tail_s = 1'b0;
        if (flush) begin
            state_s = ST_EMPTY;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (push_s) begin
                        state_s     = ST_ONE;
                        head_load_s = 1'b1;
                    end else begin
                        state_s = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (push_s && pop_s) begin
                        state_s     = ST_ONE;
                        head_load_s = 1'b1;
                    end else if (push_s) begin
                        state_s     = ST_FULL;
                        tail_load_s = 1'b1;
                    end else if (pop_s) begin
                        state_s = ST_EMPTY;
                    end else begin
                        state_s = ST_ONE;
                    end
                end
                ST_FULL: begin
                    if (pop_s) begin
                        state_s          = ST_ONE;
                        head_load_s      = 1'b1;
                        head_from_tail_s = 1'b1;
                    end else begin
                        state_s = ST_FULL;
                    end
                end
                default: begin
                    state_s = ST_EMPTY;
                end
            endcase
        end
    end

    // Head slot is refilled either from the incoming result or by promoting the tail.
    always_comb begin
        head_d_data_s = F;
        head_d_addr_s = dest_addr;
        head_d_wr_s   = in_wr_s;
        if (head_from_tail_s) begin
            head_d_data_s = tail_data_r;
            head_d_addr_s = tail_addr_r;
            head_d_wr_s   = tail_wr_r;
        end else begin
            head_d_data_s = F;
            head_d_addr_s = dest_addr;
            head_d_wr_s   = in_wr_s;
        end
    end

    // State plus handshake flags, registered so in_ready never sees out_ready combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_EMPTY;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            in_ready_r  <= (state_s != ST_FULL);
            out_valid_r <= (state_s != ST_EMPTY);
        end
    end

    // Flags are architectural at acceptance time; a flush cancels the same-cycle update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status_r <= 6'b000000;
        end else if (push_s && !flush && flag_load) begin
            status_r <= pack_flags(V, C, N, Z, LCO, RCO);
        end
    end

    result_entry_reg #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_head (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (head_load_s),
        .d_data (head_d_data_s),
        .d_addr (head_d_addr_s),
        .d_wr   (head_d_wr_s),
        .q_data (out_data),
        .q_addr (out_addr),
        .q_wr   (out_wr)
    );

    result_entry_reg #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_tail (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (tail_load_s),
        .d_data (F),
        .d_addr (dest_addr),
        .d_wr   (in_wr_s),
        .q_data (tail_data_r),
        .q_addr (tail_addr_r),
        .q_wr   (tail_wr_r)
    );

endmodule

// File: tb/tb_result_skid_stage.sv
// Self-checking bench: queue-based reference model compared every cycle, plus
// directed scenarios with literal expectations.
module tb_result_skid_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] F;
    logic        V, C, N, Z, LCO, RCO;
    logic [4:0]  dest_addr;
    logic        reg_write;
    logic        flag_load;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_addr;
    logic        out_wr;
    logic [5:0]  status;

    int cmp_cnt = 0;
    int err_cnt = 0;

    typedef struct {
        logic [31:0] d;
        logic [4:0]  a;
        logic        w;
    } ent_t;

    ent_t       mq[$];
    logic       m_alive = 1'b0;
    logic [5:0] m_status = 6'b000000;
    logic       m_push;
    logic       m_pop;
    ent_t       m_new;

    result_skid_stage #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .F(F), .V(V), .C(C), .N(N), .Z(Z), .LCO(LCO), .RCO(RCO),
        .dest_addr(dest_addr), .reg_write(reg_write), .flag_load(flag_load),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_addr(out_addr), .out_wr(out_wr), .status(status)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain FIFO of at most two entries.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_alive  = 1'b0;
            m_status = 6'b000000;
        end else begin
            m_push = in_valid && m_alive && (mq.size() < 2);
            m_pop  = (mq.size() > 0) && out_ready;
            if (flush) begin
                mq.delete();
            end else begin
                if (m_pop) void'(mq.pop_front());
                if (m_push) begin
                    m_new.d = F;
                    m_new.a = dest_addr;
                    m_new.w = reg_write && (dest_addr != 5'd0);
                    mq.push_back(m_new);
                    if (flag_load) m_status = {V, C, N, Z, LCO, RCO};
                end
            end
            m_alive = 1'b1;
        end
    end

    // Compare DUT against the model mid-cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_in_ready", in_ready, 1'b0);
            chk("rst_out_valid", out_valid, 1'b0);
            chk("rst_out_data", out_data, 32'd0);
            chk("rst_status", status, 6'd0);
        end else begin
            chk("in_ready", in_ready, m_alive && (mq.size() < 2));
            chk("out_valid", out_valid, mq.size() > 0);
            chk("status", status, m_status);
            if (mq.size() > 0) begin
                chk("out_data", out_data, mq[0].d);
                chk("out_addr", out_addr, mq[0].a);
                chk("out_wr", out_wr, mq[0].w);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic vld, input logic [31:0] f, input logic [4:0] dst,
                         input logic rw, input logic fl, input logic [5:0] flg,
                         input logic ordy, input logic fls);
        in_valid  = vld;
        F         = f;
        dest_addr = dst;
        reg_write = rw;
        flag_load = fl;
        {V, C, N, Z, LCO, RCO} = flg;
        out_ready = ordy;
        flush     = fls;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 32'd0, 5'd0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0);
        tick();
        tick();
        chk("lit_rst_in_ready", in_ready, 1'b0);
        chk("lit_rst_out_valid", out_valid, 1'b0);
        rst_n = 1'b1;
        tick();
        chk("lit_ready_rises", in_ready, 1'b1);

        // Single push with one-cycle latency, then drains.
        drive(1'b1, 32'h0000_00A5, 5'd3, 1'b1, 1'b0, 6'd0, 1'b1, 1'b0);
        tick();
        drive(1'b0, 32'd0, 5'd0, 1'b0, 1'b0, 6'd0, 1'b1, 1'b0);
        chk("lit_a5_valid", out_valid, 1'b1);
        chk("lit_a5_data", out_data, 32'hA5);
        chk("lit_a5_addr", out_addr, 5'd3);
        chk("lit_a5_wr", out_wr, 1'b1);
        tick();
        chk("lit_a5_empty", out_valid, 1'b0);

        // Fill, overflow attempt, ordered retirement.
        drive(1'b1, 32'h11, 5'd1, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h22, 5'd2, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0);
        tick();
        chk("lit_full_ready", in_ready, 1'b0);
        drive(1'b1, 32'h33, 5'd4, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0);
        tick();
        chk("lit_full_head", out_data, 32'h11);
        drive(1'b0, 32'd0, 5'd0, 1'b0, 1'b0, 6'd0, 1'b1, 1'b0);
        tick();
        chk("lit_second_head", out_data, 32'h22);
        tick();
        chk("lit_drained", out_valid, 1'b0);

        // Write to register 0 is suppressed but still occupies a slot.
        drive(1'b1, 32'h5A, 5'd0, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0);
        tick();
        chk("lit_r0_valid", out_valid, 1'b1);
        chk("lit_r0_wr", out_wr, 1'b0);
        drive(1'b0, 32'd0, 5'd0, 1'b0, 1'b0, 6'd0, 1'b1, 1'b0);
        tick();

        // Flags load only with flag_load.
        drive(1'b1, 32'h1, 5'd5, 1'b1, 1'b1, 6'b100000, 1'b1, 1'b0);
        tick();
        drive(1'b1, 32'h2, 5'd6, 1'b1, 1'b0, 6'b000100, 1'b1, 1'b0);
        tick();
        chk("lit_status", status, 6'b100000);
        drive(1'b0, 32'd0, 5'd0, 1'b0, 1'b1, 6'b111111, 1'b1, 1'b0);
        tick();
        tick();
        chk("lit_status_hold", status, 6'b100000);

        // Flush while full with simultaneous push and pop.
        drive(1'b1, 32'h77, 5'd7, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h88, 5'd8, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h99, 5'd9, 1'b1, 1'b1, 6'b011111, 1'b1, 1'b1);
        tick();
        drive(1'b0, 32'd0, 5'd0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0);
        chk("lit_flush_valid", out_valid, 1'b0);
        chk("lit_flush_ready", in_ready, 1'b1);
        chk("lit_flush_status", status, 6'b100000);

        // Randomized traffic.
        for (int i = 0; i < 2000; i++) begin
            drive($urandom_range(0, 1) == 1, $urandom, 5'($urandom_range(0, 31)),
                  $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                  6'($urandom_range(0, 63)), $urandom_range(0, 2) != 0,
                  $urandom_range(0, 15) == 0);
            tick();
        end

        // Asynchronous reset mid-cycle while full.
        drive(1'b1, 32'hAA, 5'd10, 1'b1, 1'b1, 6'b010101, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'hBB, 5'd11, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0);
        tick();
        drive(1'b0, 32'd0, 5'd0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0);
        tick();
        chk("lit_pre_rst_full", in_ready, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("lit_async_valid", out_valid, 1'b0);
        chk("lit_async_data", out_data, 32'd0);
        chk("lit_async_addr", out_addr, 5'd0);
        chk("lit_async_wr", out_wr, 1'b0);
        chk("lit_async_status", status, 6'd0);
        chk("lit_async_ready", in_ready, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("lit_rerelease_ready", in_ready, 1'b1);
        chk("lit_rerelease_valid", out_valid, 1'b0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/result_skid_stage.md
RESULT_SKID_STAGE -- requirements
Module: result_skid_stage

Interface
REQ-001 Parameter DATA_W, default 32, result width.
REQ-002 Parameter ADDR_W, default 5, destination register address width.
REQ-003 The block SHALL have a single clock and an asynchronous, active-low reset.
REQ-004 clk  input  1  sole clock, rising-edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 in_valid  input  1  upstream function-unit result valid.
REQ-007 in_ready  output  1  stage can accept an entry this cycle.
REQ-008 F  input  DATA_W  function-unit result.
REQ-009 V, C, N, Z, LCO, RCO  input  1 each  function-unit flags.
REQ-010 dest_addr  input  ADDR_W  destination register.
REQ-011 reg_write  input  1  result is to be written to the register file.
REQ-012 flag_load  input  1  flags update the status register.
REQ-013 flush  input  1  synchronous discard of all buffered entries.
REQ-014 out_valid  output  1  head entry valid toward the register-file write port.
REQ-015 out_ready  input  1  register-file write port accepts the head entry.
REQ-016 out_data  output  DATA_W  head entry result.
REQ-017 out_addr  output  ADDR_W  head entry destination.
REQ-018 out_wr  output  1  head entry write enable.
REQ-019 status  output  6  architectural flags {V,C,N,Z,LCO,RCO}, bit 5 = V.

Function
REQ-020 The block SHALL be a 2-entry in-order buffer with states EMPTY, ONE and FULL.
REQ-021 An input transfer SHALL occur when in_valid && in_ready; an output transfer SHALL occur when out_valid && out_ready.
REQ-022 in_ready SHALL be 1 in EMPTY and ONE and 0 in FULL, derived from registered state only, with no combinational path from out_ready.
REQ-023 out_valid SHALL be 1 exactly in ONE and FULL, and out_data, out_addr and out_wr SHALL always present the oldest entry.
REQ-024 Transitions: EMPTY+push to ONE; ONE+push only to FULL; ONE+pop only to EMPTY; ONE+push+pop to ONE, with the new entry becoming head next cycle; FULL+pop to ONE; all other cases hold state.
REQ-025 Latency: an entry accepted in cycle t SHALL be visible at the outputs in cycle t+1 when the buffer was EMPTY.
REQ-026 A stored entry's out_wr SHALL equal reg_write && (dest_addr != 0), so writes to register 0 are suppressed but still occupy a slot.
REQ-027 status SHALL update at the clock edge of input acceptance, not at retirement, loading {V,C,N,Z,LCO,RCO} when flag_load=1 and holding otherwise.
REQ-028 status SHALL NOT change on cycles without an input transfer, regardless of flag_load.
REQ-029 When flush=1, the next state SHALL be EMPTY and any simultaneous push and pop SHALL be ignored, including their status update; status itself SHALL NOT be cleared.
REQ-030 Head entry outputs SHALL remain stable while out_valid=1 and out_ready=0.
REQ-031 Entries SHALL never be reordered, duplicated or dropped except by flush.

Reset
REQ-032 While rst_n=0: state=EMPTY, in_ready=0, out_valid=0, out_data=0, out_addr=0, out_wr=0, status=0.
REQ-033 in_ready SHALL rise in the first clk edge after rst_n deasserts, and reset mid-transfer SHALL discard all entries with no partial write.

Structure
REQ-034 A shared package SHALL hold DATA_W/ADDR_W defaults, the state encoding (EMPTY=2'b00, ONE=2'b01, FULL=2'b10) and status bit-index constants.
REQ-035 One sub-module, result_entry_reg, SHALL hold one entry {data, addr, wr} with load enable; the stage SHALL instantiate it twice plus its own state and status logic.

Verification
REQ-036 Reset then single push F=0x0000_00A5, dest=3, reg_write=1, out_ready=1 -> next cycle out_valid=1, out_data=0xA5, out_addr=3, out_wr=1; following cycle EMPTY.
REQ-037 out_ready=0, push 0x11 then 0x22 -> FULL, in_ready=0, third push ignored; raise out_ready -> 0x11 then 0x22 retire in order.
REQ-038 Push dest=0, reg_write=1 -> out_valid=1, out_wr=0.
REQ-039 Push with flags V=1,Z=0 and flag_load=1, then push Z=1 with flag_load=0 -> status=6'b100000 after both pushes.
REQ-040 FULL plus flush=1 together with in_valid=1 and out_ready=1 -> next cycle EMPTY, out_valid=0, status unchanged.
REQ-041 Assert rst_n=0 asynchronously mid-cycle while FULL -> outputs zero immediately, without waiting for a clock edge.
